// File: rtl/mux_operand_stage.sv
// mux_operand_stage
//   Operand feeder for the 2-bit gate-level mux netlist. It buffers (A, B, sel)
//   operand sets in a small FIFO and presents one set per cycle on a
//   registered output under a valid/ready handshake.
//
//   While nothing new is loaded, A/B/sel keep their last value, so the mux
//   netlist sees no switching activity.
//
//   The output register is not part of the FIFO. Total capacity is therefore
//   DEPTH+1 operand sets.
//
//   in_ready depends only on the stored occupancy. There is no combinational
//   path from out_ready to in_ready.
//
//   Optional feature, selected by the macro SEL_TOGGLE_EN:
//     defined   - in_sel is ignored. Accepted sets carry an internally toggled
//                 select bit (0,1,0,1,...), starting at 0 after reset.
//     undefined - sel is stored per entry from in_sel.
//
//   Reset rst is asynchronous in both assertion and effect. The reset source
//   is expected to release it in step with clk.
module mux_operand_stage #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             sel,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * WIDTH + 1;

  // FIFO storage, one entry packed as {sel, b, a}
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sel_q, sel_d;

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               out_free;
  logic               wr_sel;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;

  // The output register can take a new set when it is idle, or when its
  // current set is being consumed in this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign pop      = out_free && !fifo_empty;

`ifdef SEL_TOGGLE_EN
  logic toggle_q;
  logic unused_in_sel;

  assign unused_in_sel = in_sel;
  assign wr_sel        = toggle_q;

  // Toggle bit flips on every accepted set, so stored selects alternate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= 1'b0;
    end else if (push) begin
      toggle_q <= !toggle_q;
    end
  end
`else
  assign wr_sel = in_sel;
`endif

  assign wr_entry   = {wr_sel, in_b, in_a};
  assign head_entry = mem_q[rd_ptr_q];

  // FIFO write port; storage carries no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state for the presented set; data only moves on a load
  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;

    if (pop) begin
      out_valid_d = 1'b1;
      a_d         = head_entry[WIDTH-1:0];
      b_d         = head_entry[2*WIDTH-1:WIDTH];
      sel_d       = head_entry[ENTRY_W-1];
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end

  // FIFO control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output register; A/B/sel reset to zero so the mux starts from a known value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign sel       = sel_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mux_operand_stage.sv
// Testbench for mux_operand_stage.
//   A negedge scoreboard records every accepted set and compares every
//   consumed set against it. The scenario tasks add their own inline checks.
//   Compile with +define+SEL_TOGGLE_EN to exercise the toggled-select build.
module tb_mux_operand_stage;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
  } set_t;

  set_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;
  logic tb_tg    = 1'b0;

  logic [WIDTH-1:0] prev_a = '0;
  logic [WIDTH-1:0] prev_b = '0;
  logic             prev_s = 1'b0;
  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;

  mux_operand_stage #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Scoreboard and hold monitor. Handshakes are stable at the negedge.
  always @(negedge clk or posedge rst) begin
    set_t exp;
    set_t got;
    if (rst) begin
      sb.delete();
      tb_tg  = 1'b0;
      prev_a = '0;
      prev_b = '0;
      prev_s = 1'b0;
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (!out_valid) begin
        checks++;
        if ({A, B, sel} !== {prev_a, prev_b, prev_s}) begin
          failures++;
          $display("FAIL freeze_idle: A/B/sel=%b/%b/%b required %b/%b/%b",
                   A, B, sel, prev_a, prev_b, prev_s);
        end
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (!out_valid || {A, B, sel} !== {prev_a, prev_b, prev_s}) begin
          failures++;
          $display("FAIL hold_stalled: valid=%b A/B/sel=%b/%b/%b required 1 %b/%b/%b",
                   out_valid, A, B, sel, prev_a, prev_b, prev_s);
        end
      end
      checks++;
      if (in_ready !== (count != CNT_W'(DEPTH)) || count > CNT_W'(DEPTH)) begin
        failures++;
        $display("FAIL ready_count: in_ready=%b count=%0d", in_ready, count);
      end
      if (in_valid && in_ready) begin
`ifdef SEL_TOGGLE_EN
        exp = '{a: in_a, b: in_b, s: tb_tg};
`else
        exp = '{a: in_a, b: in_b, s: in_sel};
`endif
        tb_tg = ~tb_tg;
        sb.push_back(exp);
      end
      if (out_valid && out_ready) begin
        checks++;
        got = '{a: A, b: B, s: sel};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_order: unexpected output %b/%b/%b required none", A, B, sel);
        end else begin
          exp = sb.pop_front();
          popped++;
          if (got !== exp) begin
            failures++;
            $display("FAIL sb_order: got %b/%b/%b required %b/%b/%b",
                     got.a, got.b, got.s, exp.a, exp.b, exp.s);
          end
        end
      end
      prev_a = A;
      prev_b = B;
      prev_s = sel;
      prev_v = out_valid;
      prev_r = out_ready;
    end
  end

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== 0 || out_valid !== 1'b0 || A !== 0 || B !== 0 || sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: count=%0d valid=%b A=%b B=%b sel=%b required 0 0 00 00 0",
               count, out_valid, A, B, sel);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || count !== 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b count=%0d valid=%b required 1 0 0",
               in_ready, count, out_valid);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      failures++;
      $display("FAIL %s_drain: %0d sets left required 0", name, sb.size());
    end
  endtask

`ifdef SEL_TOGGLE_EN
  task automatic test_toggle();
    logic seen [$];
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i < 4);
      in_sel   = 1'b1;
      in_a     = WIDTH'(i);
      in_b     = WIDTH'(i + 1);
      @(negedge clk);
      if (out_valid && out_ready) seen.push_back(sel);
    end
    in_valid = 1'b0;
    checks++;
    if (seen.size() != 4) begin
      failures++;
      $display("FAIL toggle_count: %0d beats required 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL toggle_seq[%0d]: sel=%b required %b", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_single();
    logic exp_s;
`ifdef SEL_TOGGLE_EN
    exp_s = tb_tg;
`else
    exp_s = 1'b1;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 2'b01;
    in_b     = 2'b10;
    in_sel   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 2'b11;
    in_b     = 2'b11;
    in_sel   = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: out_valid=%b after 1 edge required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || A !== 2'b01 || B !== 2'b10 || sel !== exp_s) begin
      failures++;
      $display("FAIL single_load: valid=%b A=%b B=%b sel=%b required 1 01 10 %b",
               out_valid, A, B, sel, exp_s);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || A !== 2'b01 || B !== 2'b10 || sel !== exp_s) begin
      failures++;
      $display("FAIL single_hold: valid=%b A=%b B=%b sel=%b required 0 01 10 %b",
               out_valid, A, B, sel, exp_s);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = WIDTH'(i);
      in_b     = WIDTH'(3 - (i % 4));
      in_sel   = i[0];
      @(negedge clk);
      checks++;
      if (in_ready !== (i < 5)) begin
        failures++;
        $display("FAIL fill_ready[%0d]: in_ready=%b required %b", i, in_ready, (i < 5));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (count !== CNT_W'(DEPTH) || in_ready !== 1'b0 || sb.size() != 5) begin
      failures++;
      $display("FAIL fill_full: count=%0d in_ready=%b held=%0d required 4 0 5",
               count, in_ready, sb.size());
    end
    drain(20, "fill");
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = WIDTH'(i);
      in_b     = WIDTH'(i >> 2);
      in_sel   = i[1];
      @(negedge clk);
      if (out_valid) beats++;
      checks++;
      if (in_ready !== 1'b1 || (i >= 1 && count !== 1) || (i >= 2 && out_valid !== 1'b1)) begin
        failures++;
        $display("FAIL b2b_steady[%0d]: in_ready=%b count=%0d valid=%b required 1 1 1",
                 i, in_ready, count, out_valid);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) beats++;
    end
    checks++;
    if (beats != 12) begin
      failures++;
      $display("FAIL b2b_beats: %0d beats required 12", beats);
    end
  endtask

  task automatic test_random();
    int  sent = 0;
    int  cyc  = 0;
    int  pop0;
    bit  acc  = 1'b0;
    pop0     = popped;
    in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_sel   = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sent++;
      end
      cyc++;
    end
    checks++;
    if (sent != 1000) begin
      failures++;
      $display("FAIL random_sent: %0d accepted required 1000", sent);
    end
    drain(50, "random");
    checks++;
    if (popped - pop0 != sent) begin
      failures++;
      $display("FAIL random_count: %0d consumed required %0d", popped - pop0, sent);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = 2'b11;
      in_b     = WIDTH'(i);
      in_sel   = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: count=%0d valid=%b required 3 1", count, out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 0 || out_valid !== 1'b0 || A !== 0 || B !== 0 || sel !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: count=%0d valid=%b A=%b B=%b sel=%b required 0 0 00 00 0",
               count, out_valid, A, B, sel);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 0 || out_valid !== 1'b0 || A !== 0 || B !== 0 || sel !== 1'b0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_after: count=%0d valid=%b A=%b B=%b sel=%b rdy=%b required 0 0 00 00 0 1",
               count, out_valid, A, B, sel, in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || count !== 0) begin
      failures++;
      $display("FAIL midrst_quiet: valid=%b count=%0d required 0 0", out_valid, count);
    end
  endtask

  initial begin
    test_reset();
`ifdef SEL_TOGGLE_EN
    test_toggle();
`endif
    test_single();
    test_fill();
    test_back_to_back();
    drain(20, "b2b");
    test_random();
    test_mid_reset();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
